cat_command_parser: RTL and testbench
=====================================

Name: cat_command_parser

Overview:
Consumes the byte stream popped from the UART receive FIFO and turns it into the 8-bit cat_status mask that drives the LED overlay. It replaces the ad-hoc single-byte compare logic with a framed, handshaked parser. Beyond single-byte hit/restore commands, it supports a whole-mask load frame and a '?' status query. The query reply is handed to the UART transmit side as ASCII bytes.

Parameters:
CLK_FREQ, 103_340_000, clock frequency in Hz
TIMEOUT_MS, 50, inter-byte timeout within a mask-load frame, in ms (used only with the optional feature)
ERR_W, 8, width of the saturating error counter

Ports:
clk  input  1  system clock
reset_n  input  1  synchronous active-low reset
rx_data  input  8  received byte at head of UART RX FIFO
rx_valid  input  1  rx_data holds a valid byte
rx_ready  output  1  parser accepts rx_data this cycle (FIFO pop)
tx_data  output  8  response byte to UART TX
tx_valid  output  1  tx_data valid
tx_ready  input  1  TX side accepts tx_data this cycle
cat_status  output  8  cat mask; 1 = cat alive
cmd_strobe  output  1  one-cycle pulse on any cat_status write
err_count  output  ERR_W  saturating count of malformed frames

Behaviour:
- Reset (sampled on clk edge while reset_n=0) is synchronous and active-low:
  - state=IDLE, cat_status=8'hFF, err_count=0, cmd_strobe=0, tx_valid=0, tx_data=0, any partial frame discarded.
  - Reset overrides a pending tx_valid: the byte is dropped.
- Byte accept occurs on rx_valid && rx_ready. rx_ready=1 only in IDLE, HEX_HI, HEX_LO and TERM. It is 0 in the RESP_* states and during reset.
- IDLE:
  - 'A'..'H' (0x41-0x48): clear cat_status[byte-0x41].
  - 'a'..'h' (0x61-0x68): set cat_status[byte-0x61].
  - '#' -> HEX_HI.
  - '?' -> latch cat_status into a snapshot register, go to RESP_HI.
  - Any other byte is ignored: no error, stay in IDLE.
- HEX_HI: a hex digit ('0'-'9', 'A'-'F', 'a'-'f') stores the high nibble, go to HEX_LO. Anything else: err_count++, go to IDLE, byte discarded (never reinterpreted as a command).
- HEX_LO: same rule as HEX_HI for the low nibble, then go to TERM.
- TERM: '\n' (0x0A) or ';' (0x3B) loads cat_status = {hi,lo} and returns to IDLE. Anything else: err_count++, go to IDLE, mask unchanged.
- RESP_HI / RESP_LO / RESP_NL:
  - tx_valid=1; tx_data = uppercase ASCII hex of snapshot[7:4], then snapshot[3:0], then 0x0A.
  - tx_data is held stable until tx_ready. Each handshake advances to the next state; after RESP_NL, go to IDLE.
  - Snapshot is unaffected by later mask writes.
- Latency:
  - cat_status updates on the clock edge that accepts the command/terminator byte, i.e. visible the next cycle.
  - cmd_strobe is high in that same next cycle only. It pulses even if the written value is unchanged.
  - First tx_valid is asserted in the cycle after '?' is accepted.
- err_count saturates at all-ones; no wrap.
- Throughput: one byte per cycle in the parse states; back-to-back single-byte commands apply in consecutive cycles.

Optional Feature:
PARSER_TIMEOUT_EN
- Defined:
  - A counter of width clog2(CLK_FREQ/1000*TIMEOUT_MS) runs in HEX_HI, HEX_LO and TERM.
  - It clears on every accepted byte and on entry to those states.
  - On reaching CLK_FREQ/1000*TIMEOUT_MS-1: go to IDLE, err_count++, partial frame dropped.
  - The counter is idle (held at 0) in IDLE and RESP_*; there is no timeout on tx_ready back-pressure.
- Undefined: no counter logic; the parser waits indefinitely inside a '#' frame.

Test Plan:
- Reset, then bytes 'C','a','H': cat_status FF -> FB -> FB -> 7B; three cmd_strobe pulses; err_count=0.
- "#3c\n" with rx_valid held high: four consecutive accepts; cat_status=8'h3C one cycle after '\n' accept; cmd_strobe once.
- "#3G", then 'B': err_count=1, state returns to IDLE on 'G'; 'B' then clears bit1.
- cat_status=8'hA5, '?' with tx_ready low 5 cycles then high: tx_data 0x41 held stable, then 0x35, then 0x0A; rx_ready=0 throughout; an 'A' sent mid-response is not popped until after 0x0A.
- reset_n low for one cycle after "#F": cat_status=FF, state IDLE; following "0\n" is ignored, err_count=0.
- PARSER_TIMEOUT_EN, CLK_FREQ=1000, TIMEOUT_MS=5: '#', idle 5 cycles -> err_count=1, IDLE; without the macro the same stimulus then "00;" loads 8'h00.

Source files
------------

// File: rtl/cat_command_parser.sv
// cat_command_parser: framed parser turning UART RX bytes into the 8-bit cat_status LED mask.
// Latency: a mask write is visible (with a one-cycle cmd_strobe) the cycle after the accepting edge; a '?' reply starts the cycle after '?'.
// Backpressure: rx_ready drops while the hex reply is being sent; each reply byte is held on tx_data until tx_ready.
// Optional: define PARSER_TIMEOUT_EN to abandon a '#' frame after TIMEOUT_MS without a new byte.
module cat_command_parser #(
  parameter int CLK_FREQ   = 103_340_000,
  parameter int TIMEOUT_MS = 50,
  parameter int ERR_W      = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [7:0]       rx_data,
  input  logic             rx_valid,
  output logic             rx_ready,
  output logic [7:0]       tx_data,
  output logic             tx_valid,
  input  logic             tx_ready,
  output logic [7:0]       cat_status,
  output logic             cmd_strobe,
  output logic [ERR_W-1:0] err_count
);

  typedef enum logic [2:0] {
    IDLE, HEX_HI, HEX_LO, TERM, RESP_HI, RESP_LO, RESP_NL
  } state_t;

  state_t     state, state_nxt;
  logic       rx_fire, tx_fire;
  logic       rx_is_hex;
  logic [3:0] rx_nib;
  logic [3:0] hi_nib, lo_nib;
  logic [7:0] snapshot;
  logic [2:0] bit_idx;
  logic       timeout;
  logic       frame_err;
  logic       wr_en;
  logic [7:0] wr_val;

  // Uppercase ASCII hex digit for one nibble
  function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
    if (nib < 4'd10) return {4'h3, nib};
    else             return 8'h37 + {4'h0, nib};
  endfunction

  assign rx_fire = rx_valid && rx_ready;
  assign tx_fire = tx_valid && tx_ready;
  // 'A'/'a' map to bit 0 and 'H'/'h' to bit 7: low three ASCII bits minus one
  assign bit_idx = rx_data[2:0] - 3'd1;

  // Decode an ASCII hex digit, either case
  always_comb begin
    rx_is_hex = 1'b1;
    rx_nib    = 4'h0;
    if (rx_data >= 8'h30 && rx_data <= 8'h39)
      rx_nib = rx_data[3:0];
    else if ((rx_data >= 8'h41 && rx_data <= 8'h46) || (rx_data >= 8'h61 && rx_data <= 8'h66))
      rx_nib = rx_data[3:0] + 4'd9;
    else
      rx_is_hex = 1'b0;
  end

`ifdef PARSER_TIMEOUT_EN
  localparam int TO_CYCLES = CLK_FREQ / 1000 * TIMEOUT_MS;
  localparam int TO_W      = (TO_CYCLES > 1) ? $clog2(TO_CYCLES) : 1;

  logic [TO_W-1:0] to_cnt;
  logic            in_frame;

  assign in_frame = (state == HEX_HI) || (state == HEX_LO) || (state == TERM);
  // A byte arriving on the last count wins over the timeout
  assign timeout  = in_frame && !rx_fire && (to_cnt == TO_W'(TO_CYCLES - 1));

  // Inter-byte timer: runs only inside a '#' frame, restarts on every accepted byte
  always_ff @(posedge clk) begin
    if (!reset_n || !in_frame || rx_fire || timeout) to_cnt <= '0;
    else                                            to_cnt <= to_cnt + TO_W'(1);
  end
`else
  assign timeout = 1'b0;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (rx_fire) begin
        if (rx_data == 8'h23)      state_nxt = HEX_HI;
        else if (rx_data == 8'h3F) state_nxt = RESP_HI;
      end
      HEX_HI: begin
        if (rx_fire)      state_nxt = rx_is_hex ? HEX_LO : IDLE;
        else if (timeout) state_nxt = IDLE;
      end
      HEX_LO: begin
        if (rx_fire)      state_nxt = rx_is_hex ? TERM : IDLE;
        else if (timeout) state_nxt = IDLE;
      end
      TERM:    if (rx_fire || timeout) state_nxt = IDLE;
      RESP_HI: if (tx_fire) state_nxt = RESP_LO;
      RESP_LO: if (tx_fire) state_nxt = RESP_NL;
      RESP_NL: if (tx_fire) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Handshake outputs; reset forces both sides quiet
  always_comb begin
    rx_ready = 1'b0;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    if (reset_n) begin
      case (state)
        IDLE, HEX_HI, HEX_LO, TERM: rx_ready = 1'b1;
        RESP_HI: begin tx_valid = 1'b1; tx_data = hex_ascii(snapshot[7:4]); end
        RESP_LO: begin tx_valid = 1'b1; tx_data = hex_ascii(snapshot[3:0]); end
        RESP_NL: begin tx_valid = 1'b1; tx_data = 8'h0A; end
        default: ;
      endcase
    end
  end

  // Mask write and malformed-frame decode for the byte being accepted
  always_comb begin
    wr_en     = 1'b0;
    wr_val    = cat_status;
    frame_err = timeout;
    if (rx_fire) begin
      case (state)
        IDLE: begin
          if (rx_data >= 8'h41 && rx_data <= 8'h48) begin
            wr_en           = 1'b1;
            wr_val[bit_idx] = 1'b0;
          end else if (rx_data >= 8'h61 && rx_data <= 8'h68) begin
            wr_en           = 1'b1;
            wr_val[bit_idx] = 1'b1;
          end
        end
        HEX_HI, HEX_LO: frame_err = !rx_is_hex;
        TERM: begin
          if (rx_data == 8'h0A || rx_data == 8'h3B) begin
            wr_en  = 1'b1;
            wr_val = {hi_nib, lo_nib};
          end else begin
            frame_err = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Cat mask register and its write strobe
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cat_status <= 8'hFF;
      cmd_strobe <= 1'b0;
    end else begin
      cmd_strobe <= wr_en;
      if (wr_en) cat_status <= wr_val;
    end
  end

  // Saturating malformed-frame counter
  always_ff @(posedge clk) begin
    if (!reset_n)                           err_count <= '0;
    else if (frame_err && err_count != '1)  err_count <= err_count + ERR_W'(1);
  end

  // Frame nibbles and the query snapshot (frozen for the whole reply)
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      hi_nib   <= 4'h0;
      lo_nib   <= 4'h0;
      snapshot <= 8'h00;
    end else if (rx_fire) begin
      if (state == HEX_HI)                      hi_nib   <= rx_nib;
      if (state == HEX_LO)                      lo_nib   <= rx_nib;
      if (state == IDLE && rx_data == 8'h3F)    snapshot <= cat_status;
    end
  end

endmodule

// File: tb/tb_cat_command_parser.sv
// Scoreboard bench for cat_command_parser: expected mask writes and reply bytes are queued
// as stimulus is driven and popped when cmd_strobe / a TX handshake appears.
module tb_cat_command_parser;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] cat_status;
  logic       cmd_strobe;
  logic [7:0] err_count;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_st[$];
  logic [7:0] exp_tx[$];

  cat_command_parser dut (
    .clk(clk), .reset_n(reset_n),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .cat_status(cat_status), .cmd_strobe(cmd_strobe), .err_count(err_count)
  );

  always #5 clk = ~clk;

  // One clock; scoreboard pops on every TX handshake and every cmd_strobe
  task automatic tick();
    logic       txf;
    logic [7:0] txd, e;
    #1;
    txf = tx_valid && tx_ready;
    txd = tx_data;
    @(posedge clk);
    #1;
    if (txf) begin
      checks++;
      if (exp_tx.size() == 0) begin
        errors++; $display("FAIL tx_unexpected got %h", txd);
      end else begin
        e = exp_tx.pop_front();
        if (txd !== e) begin errors++; $display("FAIL tx_byte got %h exp %h", txd, e); end
      end
    end
    if (cmd_strobe) begin
      checks++;
      if (exp_st.size() == 0) begin
        errors++; $display("FAIL strobe_unexpected cat_status %h", cat_status);
      end else begin
        e = exp_st.pop_front();
        if (cat_status !== e) begin errors++; $display("FAIL cat_status got %h exp %h", cat_status, e); end
      end
    end
  endtask

  // Present one byte, wait (bounded) for rx_ready, accept on the next edge
  task automatic send_byte(input logic [7:0] b, output int waited);
    rx_valid = 1'b1;
    rx_data  = b;
    waited   = 0;
    #1;
    while (!rx_ready && waited < 50) begin tick(); waited++; end
    if (waited >= 50) begin
      checks++; errors++; $display("FAIL rx_ready_timeout byte %h waited %0d", b, waited);
    end
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic send_str(input string s, output int total_wait);
    int w;
    total_wait = 0;
    for (int i = 0; i < s.len(); i++) begin
      send_byte(s[i], w);
      total_wait += w;
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; rx_valid = 1'b0; rx_data = 8'h00; tx_ready = 1'b0;
    tick(); tick();
    checks++; if (cat_status !== 8'hFF) begin errors++; $display("FAIL reset_cat got %h exp FF", cat_status); end
    checks++; if (err_count !== 8'h00) begin errors++; $display("FAIL reset_err got %h exp 00", err_count); end
    checks++; if (cmd_strobe !== 1'b0 || tx_valid !== 1'b0) begin errors++; $display("FAIL reset_outs strobe %b tx_valid %b exp 0 0", cmd_strobe, tx_valid); end
    checks++; if (rx_ready !== 1'b0) begin errors++; $display("FAIL reset_rx_ready got %b exp 0", rx_ready); end
    reset_n = 1'b1;
    #1;
    checks++; if (rx_ready !== 1'b1) begin errors++; $display("FAIL idle_rx_ready got %b exp 1", rx_ready); end
  endtask

  task automatic test_single_cmds();
    int w;
    exp_st.push_back(8'hFB); exp_st.push_back(8'hFB); exp_st.push_back(8'h7B);
    send_str("CaH", w);
    checks++; if (w != 0) begin errors++; $display("FAIL single_b2b waited %0d exp 0", w); end
    checks++; if (exp_st.size() != 0) begin errors++; $display("FAIL single_strobes missing %0d exp 0", exp_st.size()); end
    checks++; if (cat_status !== 8'h7B || err_count !== 8'h00) begin errors++; $display("FAIL single_final cat %h err %h exp 7B 00", cat_status, err_count); end
  endtask

  task automatic test_mask_load();
    int w;
    exp_st.push_back(8'h3C);
    send_str("#3c\n", w);
    checks++; if (w != 0) begin errors++; $display("FAIL load_b2b waited %0d exp 0", w); end
    checks++; if (cat_status !== 8'h3C || exp_st.size() != 0) begin errors++; $display("FAIL load_mask got %h pending %0d exp 3C 0", cat_status, exp_st.size()); end
    tick();
    checks++; if (cmd_strobe !== 1'b0) begin errors++; $display("FAIL load_strobe_width got %b exp 0", cmd_strobe); end
  endtask

  task automatic test_bad_frame();
    int w;
    send_str("#3G", w);
    checks++; if (err_count !== 8'd1 || rx_ready !== 1'b1) begin errors++; $display("FAIL bad_frame err %h rx_ready %b exp 01 1", err_count, rx_ready); end
    exp_st.push_back(8'h3C);  // 'B' clears bit1, already 0: strobe still pulses
    send_byte(8'h42, w);
    checks++; if (cat_status !== 8'h3C || exp_st.size() != 0) begin errors++; $display("FAIL after_bad got %h pending %0d exp 3C 0", cat_status, exp_st.size()); end
    exp_st.push_back(8'h3E);  // 'b' sets bit1: proves state is IDLE
    send_byte(8'h62, w);
    checks++; if (cat_status !== 8'h3E) begin errors++; $display("FAIL set_b got %h exp 3E", cat_status); end
  endtask

  task automatic test_query();
    int w;
    exp_st.push_back(8'hA5);
    send_str("#A5;", w);
    tx_ready = 1'b0;
    exp_tx.push_back(8'h41); exp_tx.push_back(8'h35); exp_tx.push_back(8'h0A);
    send_byte(8'h3F, w);
    checks++; if (tx_valid !== 1'b1 || tx_data !== 8'h41) begin errors++; $display("FAIL query_first tx_valid %b data %h exp 1 41", tx_valid, tx_data); end
    rx_valid = 1'b1; rx_data = 8'h41;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++;
      if (rx_ready !== 1'b0 || tx_valid !== 1'b1 || tx_data !== 8'h41) begin
        errors++; $display("FAIL query_hold rx_ready %b tx_valid %b data %h exp 0 1 41", rx_ready, tx_valid, tx_data);
      end
      tick();
    end
    tx_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (rx_ready !== 1'b0) begin errors++; $display("FAIL query_rx_block got %b exp 0", rx_ready); end
      tick();
    end
    checks++; if (rx_ready !== 1'b1 || tx_valid !== 1'b0) begin errors++; $display("FAIL query_end rx_ready %b tx_valid %b exp 1 0", rx_ready, tx_valid); end
    checks++; if (exp_tx.size() != 0) begin errors++; $display("FAIL query_bytes pending %0d exp 0", exp_tx.size()); end
    exp_st.push_back(8'hA4);
    tick();
    rx_valid = 1'b0; tx_ready = 1'b0;
    checks++; if (cat_status !== 8'hA4 || exp_st.size() != 0) begin errors++; $display("FAIL query_late_A got %h pending %0d exp A4 0", cat_status, exp_st.size()); end
  endtask

  task automatic test_reset_midframe();
    int w;
    send_str("#F", w);
    reset_n = 1'b0;
    tick();
    checks++; if (rx_ready !== 1'b0) begin errors++; $display("FAIL midreset_rx_ready got %b exp 0", rx_ready); end
    reset_n = 1'b1;
    checks++; if (cat_status !== 8'hFF || err_count !== 8'h00) begin errors++; $display("FAIL midreset cat %h err %h exp FF 00", cat_status, err_count); end
    send_str("0\n", w);
    tick();
    checks++; if (cat_status !== 8'hFF || err_count !== 8'h00 || exp_st.size() != 0) begin
      errors++; $display("FAIL midreset_tail cat %h err %h pending %0d exp FF 00 0", cat_status, err_count, exp_st.size());
    end
  endtask

  task automatic test_no_timeout();
    int w;
    send_byte(8'h23, w);
    for (int i = 0; i < 20; i++) tick();
    checks++; if (err_count !== 8'h00) begin errors++; $display("FAIL no_timeout err got %h exp 00", err_count); end
    exp_st.push_back(8'h00);
    send_str("00;", w);
    checks++; if (cat_status !== 8'h00 || exp_st.size() != 0) begin errors++; $display("FAIL no_timeout_load got %h exp 00", cat_status); end
  endtask

  task automatic test_err_saturation();
    int w;
    for (int i = 0; i < 255; i++) send_str("#x", w);
    checks++; if (err_count !== 8'hFF) begin errors++; $display("FAIL err_at_max got %h exp FF", err_count); end
    for (int i = 0; i < 5; i++) send_str("#x", w);
    checks++; if (err_count !== 8'hFF) begin errors++; $display("FAIL err_saturate got %h exp FF", err_count); end
  endtask

  initial begin
    test_reset();
    test_single_cmds();
    test_mask_load();
    test_bad_frame();
    test_query();
    test_reset_midframe();
    test_no_timeout();
    test_err_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
